// File: rtl/vec_assembler_if.sv
// vec_assembler_if: sub-vector/count input bus and valid/ready fingerprint output bus of vec_assembler
// (VEC_ASSEMBLER_CNT_CHECK_EN adds o_CntMismatch)
interface vec_assembler_if #(
    parameter int VECTOR_WIDTH = 920,
    parameter int BUS_WIDTH    = 512,
    parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH)
);
    logic [BUS_WIDTH-1:0]    i_SubVector;
    logic                    i_Valid;
    logic [CNT_WIDTH-1:0]    i_Cnt;
    logic                    i_CntNew;
    logic [VECTOR_WIDTH-1:0] o_Vector;
    logic [CNT_WIDTH-1:0]    o_Cnt;
    logic                    o_Valid;
    logic                    i_Ready;
    logic                    o_Overflow;
    logic                    o_ProtoErr;
`ifdef VEC_ASSEMBLER_CNT_CHECK_EN
    logic                    o_CntMismatch;
`endif
    modport master (
        output i_SubVector, i_Valid, i_Cnt, i_CntNew, i_Ready,
        input  o_Vector, o_Cnt, o_Valid, o_Overflow, o_ProtoErr
`ifdef VEC_ASSEMBLER_CNT_CHECK_EN
        , input o_CntMismatch
`endif
    );
    modport slave (
        input  i_SubVector, i_Valid, i_Cnt, i_CntNew, i_Ready,
        output o_Vector, o_Cnt, o_Valid, o_Overflow, o_ProtoErr
`ifdef VEC_ASSEMBLER_CNT_CHECK_EN
        , output o_CntMismatch
`endif
    );
endinterface

// File: rtl/vec_assembler.sv
// vec_assembler: packs SUB_VECTOR_NO bus beats into one fingerprint, pairs it with its popcount and
// queues it in a 2-entry valid/ready FIFO; VEC_ASSEMBLER_CNT_CHECK_EN re-counts every pushed vector
module vec_assembler #(
    parameter int VECTOR_WIDTH  = 920,
    parameter int BUS_WIDTH     = 512,
    parameter int SUB_VECTOR_NO = 2,
    parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH),
    parameter int FIFO_DEPTH    = 2
) (
    input logic            clk,
    input logic            rst,
    vec_assembler_if.slave bus
);
    localparam int ASM_W = BUS_WIDTH * SUB_VECTOR_NO;
    localparam int WC_W  = $clog2(SUB_VECTOR_NO) + 1;
    localparam logic [WC_W-1:0] LAST_IDX = WC_W'(SUB_VECTOR_NO - 1);
    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    logic [WC_W-1:0]         wc_q, wc_d;
    logic [ASM_W-1:0]        asm_q, asm_d, full_vec;
    logic [VECTOR_WIDTH-1:0] head_vec_q, head_vec_d, tail_vec_q, tail_vec_d, push_vec;
    logic [CNT_WIDTH-1:0]    head_cnt_q, head_cnt_d, tail_cnt_q, tail_cnt_d, push_cnt;
    logic [1:0]              level_q, level_d, level_mid;
    logic                    ovf_q, ovf_d, perr_q, perr_d;
    logic                    last, pop, accept;
    logic                    unused_bits;

    // the final slice bypasses the assembly register; bits above VECTOR_WIDTH are dropped
    assign unused_bits = ^{asm_q[ASM_W-1 -: BUS_WIDTH], full_vec};

    // beat counting, packing, count contract and queue bookkeeping (pop before push)
    always_comb begin
        last     = bus.i_Valid && (wc_q == LAST_IDX);
        pop      = (level_q != 2'd0) && bus.i_Ready;
        accept   = last && ((level_q < DEPTH) || pop);
        full_vec = asm_q;
        full_vec[(SUB_VECTOR_NO-1)*BUS_WIDTH +: BUS_WIDTH] = bus.i_SubVector;
        push_vec = full_vec[VECTOR_WIDTH-1:0];
        push_cnt = bus.i_CntNew ? bus.i_Cnt : '0;
        wc_d     = bus.i_Valid ? (last ? '0 : wc_q + WC_W'(1)) : wc_q;
        asm_d    = asm_q;
        for (int k = 0; k < SUB_VECTOR_NO; k++)
            if (bus.i_Valid && wc_q == WC_W'(k)) asm_d[k*BUS_WIDTH +: BUS_WIDTH] = bus.i_SubVector;
        level_mid  = level_q - {1'b0, pop};
        head_vec_d = (accept && level_mid == 2'd0) ? push_vec
                   : (pop && level_q == 2'd2) ? tail_vec_q : head_vec_q;
        head_cnt_d = (accept && level_mid == 2'd0) ? push_cnt
                   : (pop && level_q == 2'd2) ? tail_cnt_q : head_cnt_q;
        tail_vec_d = (accept && level_mid != 2'd0) ? push_vec : tail_vec_q;
        tail_cnt_d = (accept && level_mid != 2'd0) ? push_cnt : tail_cnt_q;
        level_d    = level_mid + {1'b0, accept};
        ovf_d      = ovf_q || (last && !accept);
        perr_d     = perr_q || (bus.i_CntNew != last);
    end

    // state registers
    always_ff @(posedge clk) begin
        wc_q       <= rst ? '0 : wc_d;
        asm_q      <= rst ? '0 : asm_d;
        head_vec_q <= rst ? '0 : head_vec_d;
        head_cnt_q <= rst ? '0 : head_cnt_d;
        tail_vec_q <= rst ? '0 : tail_vec_d;
        tail_cnt_q <= rst ? '0 : tail_cnt_d;
        level_q    <= rst ? '0 : level_d;
        ovf_q      <= rst ? 1'b0 : ovf_d;
        perr_q     <= rst ? 1'b0 : perr_d;
    end

    assign bus.o_Vector   = head_vec_q;
    assign bus.o_Cnt      = head_cnt_q;
    assign bus.o_Valid    = level_q != 2'd0;
    assign bus.o_Overflow = ovf_q;
    assign bus.o_ProtoErr = perr_q;

`ifdef VEC_ASSEMBLER_CNT_CHECK_EN
    localparam int GRAN = 64;
    localparam int NG   = (VECTOR_WIDTH + GRAN - 1) / GRAN;
    localparam int GC_W = $clog2(GRAN + 1);
    localparam int PC_W = $clog2(VECTOR_WIDTH + 1);

    logic [NG*GRAN-1:0] padded;
    logic [GC_W-1:0]    gcnt_q [NG];
    logic [GC_W-1:0]    gcnt_d [NG];
    logic [PC_W-1:0]    ecnt_q, ecnt_d, sum;
    logic               chk_q, chk_d, mism_q, mism_d;

    // stage 1 counts each granule of the pushed vector, stage 2 sums granules and compares
    always_comb begin
        padded = '0;
        padded[VECTOR_WIDTH-1:0] = push_vec;
        for (int g = 0; g < NG; g++) begin
            gcnt_d[g] = '0;
            for (int b = 0; b < GRAN; b++) gcnt_d[g] = gcnt_d[g] + GC_W'(padded[g*GRAN+b]);
        end
        ecnt_d = PC_W'(push_cnt);
        chk_d  = last;
        sum    = '0;
        for (int g = 0; g < NG; g++) sum = sum + PC_W'(gcnt_q[g]);
        mism_d = chk_q && (sum != ecnt_q);
    end

    // popcount pipeline registers
    always_ff @(posedge clk) begin
        gcnt_q <= gcnt_d;
        ecnt_q <= ecnt_d;
        chk_q  <= rst ? 1'b0 : chk_d;
        mism_q <= rst ? 1'b0 : mism_d;
    end

    assign bus.o_CntMismatch = mism_q;
`endif
endmodule

// File: tb/tb_vec_assembler.sv
// tb_vec_assembler: table, directed and randomized checks of vec_assembler against a queue-based model
module tb_vec_assembler;
    localparam int VW  = 920;
    localparam int BW  = 512;
    localparam int SUB = 2;
    localparam int CW  = $clog2(VW);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_assembler_if #(.VECTOR_WIDTH(VW), .BUS_WIDTH(BW), .CNT_WIDTH(CW)) bus();
    vec_assembler #(.VECTOR_WIDTH(VW), .BUS_WIDTH(BW), .SUB_VECTOR_NO(SUB), .CNT_WIDTH(CW),
                    .FIFO_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [VW-1:0] v; logic [CW-1:0] c; } ent_t;
    typedef struct {
        logic v; logic [BW-1:0] s; logic cn; logic [CW-1:0] c; logic rd;
        logic ev; logic [VW-1:0] evec; logic [CW-1:0] ecnt; logic eperr;
    } row_t;

    ent_t           mq[$];
    logic [BW-1:0]  beats[$];
    logic [VW-1:0]  m_vec;
    logic [CW-1:0]  m_cnt;
    logic           m_ovf, m_perr, m_stage, m_mism;
    int             n_chk = 0;
    int             n_fail = 0;
    row_t           tbl[7];

    task automatic chk(input string nm, input logic [459:0] a, input logic [459:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [VW-1:0] a, input logic [VW-1:0] e);
        chk({nm, "_lo"}, a[459:0], e[459:0]);
        chk({nm, "_hi"}, a[919:460], e[919:460]);
    endtask

    function automatic logic [VW-1:0] pack(input logic [BW-1:0] last_beat);
        logic [BW*SUB-1:0] full = '0;
        for (int k = 0; k < beats.size(); k++) full[k*BW +: BW] = beats[k];
        full[(SUB-1)*BW +: BW] = last_beat;
        return full[VW-1:0];
    endfunction

    function automatic logic [VW-1:0] mk(input logic [BW-1:0] a, input logic [BW-1:0] b);
        return {b[VW-BW-1:0], a};
    endfunction

    function automatic logic [BW-1:0] sv(input int k);
        logic [31:0] w = 32'hA500_0000 | 32'(k);
        return {16{w}};
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [BW-1:0] s,
                              input logic cn, input logic [CW-1:0] c, input logic rd);
        bit   last;
        ent_t e;
        if (r) begin
            mq.delete(); beats.delete();
            m_vec = '0; m_cnt = '0; m_ovf = 0; m_perr = 0; m_stage = 0; m_mism = 0;
            return;
        end
        last = v && beats.size() == SUB - 1;
        if (cn != last) m_perr = 1;
        m_mism = m_stage;
        m_stage = 0;
        if (last) begin
            e.v = pack(s);
            e.c = cn ? c : '0;
            m_stage = $countones(e.v) != int'(e.c);
        end
        if (mq.size() > 0 && rd) void'(mq.pop_front());
        if (last) begin
            if (mq.size() < 2) mq.push_back(e); else m_ovf = 1;
            beats.delete();
        end else if (v) beats.push_back(s);
        if (mq.size() > 0) begin
            m_vec = mq[0].v;
            m_cnt = mq[0].c;
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [BW-1:0] s,
                         input logic cn, input logic [CW-1:0] c, input logic rd);
        rst = r; bus.i_Valid = v; bus.i_SubVector = s; bus.i_CntNew = cn; bus.i_Cnt = c; bus.i_Ready = rd;
        model_step(r, v, s, cn, c, rd);
        @(posedge clk); #1;
        chk("m_valid", bus.o_Valid, mq.size() > 0);
        chk_vec("m_vec", bus.o_Vector, m_vec);
        chk("m_cnt", bus.o_Cnt, m_cnt);
        chk("m_ovf", bus.o_Overflow, m_ovf);
        chk("m_perr", bus.o_ProtoErr, m_perr);
`ifdef VEC_ASSEMBLER_CNT_CHECK_EN
        chk("m_mism", bus.o_CntMismatch, m_mism);
`endif
    endtask

    task automatic idle(input logic rd);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, rd);
    endtask

    initial begin
        logic [VW-1:0] t1, t2;
        logic [BW-1:0] three;
        t1 = mk('1, 512'h0F);
        t2 = mk(512'h1234, 512'h5678);
        three = 512'h7;
        tbl[0] = '{1'b1, '1,          1'b0, CW'(0),   1'b1, 1'b0, '0, CW'(0),   1'b0};
        tbl[1] = '{1'b1, 512'h0F,     1'b1, CW'(516), 1'b1, 1'b1, t1, CW'(516), 1'b0};
        tbl[2] = '{1'b0, '0,          1'b0, CW'(0),   1'b1, 1'b0, t1, CW'(516), 1'b0};
        tbl[3] = '{1'b0, '0,          1'b0, CW'(0),   1'b1, 1'b0, t1, CW'(516), 1'b0};
        tbl[4] = '{1'b1, 512'h1234,   1'b1, CW'(5),   1'b1, 1'b0, t1, CW'(516), 1'b1};
        tbl[5] = '{1'b1, 512'h5678,   1'b0, CW'(0),   1'b1, 1'b1, t2, CW'(0),   1'b1};
        tbl[6] = '{1'b0, '0,          1'b0, CW'(0),   1'b1, 1'b0, t2, CW'(0),   1'b1};

        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("rst_valid", bus.o_Valid, 1'b0);
        chk_vec("rst_vec", bus.o_Vector, '0);
        chk("rst_cnt", bus.o_Cnt, '0);
        chk("rst_ovf", bus.o_Overflow, 1'b0);
        chk("rst_perr", bus.o_ProtoErr, 1'b0);

        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, tbl[i].v, tbl[i].s, tbl[i].cn, tbl[i].c, tbl[i].rd);
            chk("tbl_valid", bus.o_Valid, tbl[i].ev);
            chk_vec("tbl_vec", bus.o_Vector, tbl[i].evec);
            chk("tbl_cnt", bus.o_Cnt, tbl[i].ecnt);
            chk("tbl_perr", bus.o_ProtoErr, tbl[i].eperr);
        end

        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b0, 1'b1, sv(2*k), 1'b0, '0, 1'b0);
            cycle(1'b0, 1'b1, sv(2*k+1), 1'b1, CW'(k), 1'b0);
        end
        chk("ovf_flag", bus.o_Overflow, 1'b1);
        chk("ovf_valid", bus.o_Valid, 1'b1);
        chk_vec("ovf_v1", bus.o_Vector, mk(sv(2), sv(3)));
        chk("ovf_c1", bus.o_Cnt, CW'(1));
        idle(1'b1);
        chk_vec("ovf_v2", bus.o_Vector, mk(sv(4), sv(5)));
        chk("ovf_c2", bus.o_Cnt, CW'(2));
        idle(1'b1);
        chk("ovf_empty", bus.o_Valid, 1'b0);
        chk_vec("ovf_hold", bus.o_Vector, mk(sv(4), sv(5)));

        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            cycle(1'b0, 1'b1, sv(2*k), 1'b0, '0, 1'b0);
            cycle(1'b0, 1'b1, sv(2*k+1), 1'b1, CW'(k), 1'b0);
        end
        cycle(1'b0, 1'b1, sv(6), 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, sv(7), 1'b1, CW'(3), 1'b1);
        chk("pp_noovf", bus.o_Overflow, 1'b0);
        chk_vec("pp_v2", bus.o_Vector, mk(sv(4), sv(5)));
        idle(1'b1);
        chk_vec("pp_v3", bus.o_Vector, mk(sv(6), sv(7)));
        chk("pp_c3", bus.o_Cnt, CW'(3));
        idle(1'b1);
        chk("pp_empty", bus.o_Valid, 1'b0);

        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, sv(8), 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("mr_valid", bus.o_Valid, 1'b0);
        chk_vec("mr_vec", bus.o_Vector, '0);
        chk("mr_cnt", bus.o_Cnt, '0);
        cycle(1'b0, 1'b1, sv(10), 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, sv(11), 1'b1, CW'(7), 1'b0);
        chk("mr_valid2", bus.o_Valid, 1'b1);
        chk_vec("mr_vec2", bus.o_Vector, mk(sv(10), sv(11)));
        chk("mr_perr", bus.o_ProtoErr, 1'b0);

`ifdef VEC_ASSEMBLER_CNT_CHECK_EN
        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, three, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, '0, 1'b1, CW'(4), 1'b1);
        chk("cc_t1", bus.o_CntMismatch, 1'b0);
        idle(1'b1);
        chk("cc_t2", bus.o_CntMismatch, 1'b1);
        idle(1'b1);
        chk("cc_t3", bus.o_CntMismatch, 1'b0);
        cycle(1'b0, 1'b1, three, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, '0, 1'b1, CW'(3), 1'b1);
        idle(1'b1);
        chk("cc_ok", bus.o_CntMismatch, 1'b0);
        idle(1'b1);
`endif

        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic          r, v, cn, rd;
            logic [BW-1:0] s;
            logic [CW-1:0] c;
            r  = $urandom_range(0, 199) == 0;
            v  = $urandom_range(0, 9) < 7;
            for (int w = 0; w < BW / 32; w++) s[w*32 +: 32] = $urandom;
            cn = (v && beats.size() == SUB - 1) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 29) == 0);
            c  = $urandom_range(0, 1) ? CW'($countones(pack(s))) : CW'($urandom_range(0, VW));
            rd = $urandom_range(0, 2) != 0;
            cycle(r, v, s, cn, c, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
